// File: rtl/vip_frame_timing_counter.sv
// Raster position counter: horizontal/vertical sample indices, field tracking for
// interlaced video, colour-plane sample sequencing and line/field/frame strobes.
// Optional active-picture flag is built when VIPCTI_ACTIVE_FLAGS_EN is defined.
module vip_frame_timing_counter #(
  parameter int unsigned H_WIDTH                       = 14,
  parameter int unsigned V_WIDTH                       = 13,
  parameter int unsigned NUMBER_OF_COLOUR_PLANES       = 3,
  parameter int unsigned COLOUR_PLANES_ARE_IN_PARALLEL = 1,
  parameter int unsigned LOG2_NUMBER_OF_COLOUR_PLANES  = 2,
  parameter int unsigned TOTALS_MINUS_ONE              = 0
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_sclr,
  input  logic                                    i_enable,
  input  logic                                    i_interlaced,
  input  logic [H_WIDTH-1:0]                      i_h_total,
  input  logic [V_WIDTH-1:0]                      i_v_total_f0,
  input  logic [V_WIDTH-1:0]                      i_v_total_f1,
  input  logic [H_WIDTH-1:0]                      i_h_reset,
  input  logic [V_WIDTH-1:0]                      i_v_reset,
  input  logic                                    i_f_reset,
`ifdef VIPCTI_ACTIVE_FLAGS_EN
  input  logic [H_WIDTH-1:0]                      i_h_active_start,
  input  logic [H_WIDTH-1:0]                      i_h_active_end,
  input  logic [V_WIDTH-1:0]                      i_v_active_start,
  input  logic [V_WIDTH-1:0]                      i_v_active_end,
  output logic                                    o_active_picture,
`endif
  output logic [H_WIDTH-1:0]                      o_h_count,
  output logic [V_WIDTH-1:0]                      o_v_count,
  output logic                                    o_field,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] o_sample_ticks,
  output logic                                    o_start_of_sample,
  output logic                                    o_new_line,
  output logic                                    o_new_field,
  output logic                                    o_new_frame
);

  // Clocks per sample: sequential planes take one clock each.
  localparam int unsigned P = (COLOUR_PLANES_ARE_IN_PARALLEL != 0) ? 1 : NUMBER_OF_COLOUR_PLANES;
  localparam logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] TickLast =
      LOG2_NUMBER_OF_COLOUR_PLANES'(P - 1);

  logic [H_WIDTH-1:0]                      r_h_count;
  logic [V_WIDTH-1:0]                      r_v_count;
  logic                                    r_field;
  logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] r_sample_ticks;

  logic [H_WIDTH-1:0] w_h_last;
  logic [V_WIDTH-1:0] w_v_total;
  logic [V_WIDTH-1:0] w_v_last;
  logic               w_tick_wrap;
  logic               w_count_sample;
  logic               w_new_line;
  logic               w_new_field;
  logic               w_new_frame;

  // Last index of line/field; a zero total wraps to all-ones and counts the full range.
  always_comb begin
    w_v_total = r_field ? i_v_total_f1 : i_v_total_f0;
    if (TOTALS_MINUS_ONE != 0) begin
      w_h_last = i_h_total;
      w_v_last = w_v_total;
    end else begin
      w_h_last = i_h_total - H_WIDTH'(1);
      w_v_last = w_v_total - V_WIDTH'(1);
    end
  end

  // Boundary strobes; rst is folded into count_sample so every strobe is low under reset.
  always_comb begin
    w_tick_wrap    = (r_sample_ticks == TickLast);
    w_count_sample = i_enable && !i_rst && w_tick_wrap;
    w_new_line     = w_count_sample && (r_h_count >= w_h_last);
    w_new_field    = w_new_line && (r_v_count >= w_v_last);
    w_new_frame    = w_new_field && (!i_interlaced || r_field);
  end

  // Counter state: rst, then sclr, then line/field wrap, then plain sample advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_count      <= '0;
      r_v_count      <= '0;
      r_field        <= 1'b0;
      r_sample_ticks <= '0;
    end else if (i_sclr) begin
      r_h_count      <= i_h_reset;
      r_v_count      <= i_v_reset;
      r_field        <= i_f_reset & i_interlaced;
      r_sample_ticks <= '0;
    end else begin
      if (i_enable) begin
        r_sample_ticks <= w_tick_wrap ? '0 : r_sample_ticks + LOG2_NUMBER_OF_COLOUR_PLANES'(1);
      end
      if (w_new_line) begin
        r_h_count <= '0;
        if (w_new_field) begin
          r_v_count <= '0;
          // Dropping interlaced while in field 1 lands back on field 0 here.
          r_field   <= i_interlaced ? ~r_field : 1'b0;
        end else begin
          r_v_count <= r_v_count + V_WIDTH'(1);
        end
      end else if (w_count_sample) begin
        r_h_count <= r_h_count + H_WIDTH'(1);
      end
    end
  end

`ifdef VIPCTI_ACTIVE_FLAGS_EN
  // Active window is half-open on both axes, decoded straight from the registered counts.
  always_comb begin
    o_active_picture = !i_rst &&
                       (r_h_count >= i_h_active_start) && (r_h_count < i_h_active_end) &&
                       (r_v_count >= i_v_active_start) && (r_v_count < i_v_active_end);
  end
`endif

  // Output drive.
  always_comb begin
    o_h_count         = r_h_count;
    o_v_count         = r_v_count;
    o_field           = r_field;
    o_sample_ticks    = r_sample_ticks;
    o_start_of_sample = (r_sample_ticks == '0);
    o_new_line        = w_new_line;
    o_new_field       = w_new_field;
    o_new_frame       = w_new_frame;
  end

endmodule

// File: doc/vip_frame_timing_counter.md
# vip_frame_timing_counter

Parametrised raster position counter for the clocked-video input/output paths. It generalises the earlier fixed 14/13-bit frame counter in four ways: configurable counter widths, an internal colour-plane sample sequencer, interlaced two-field operation with separate per-field line totals, and frame/field boundary strobes. It sits between the video timing/sync logic and the pixel datapath, and supplies the position, field and boundary signals used for sync generation and for alignment.

## Interface
Parameters:
- H_WIDTH, 14, width of h_count and of the horizontal total/reset inputs.
- V_WIDTH, 13, width of v_count and of the vertical total/reset inputs.
- NUMBER_OF_COLOUR_PLANES, 3, number of colour planes per sample; must be at least 1.
- COLOUR_PLANES_ARE_IN_PARALLEL, 1, 1 means one clock per sample; 0 means NUMBER_OF_COLOUR_PLANES clocks per sample.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2, width of sample_ticks; must be at least 1.
- TOTALS_MINUS_ONE, 0, 1 means the total inputs already hold the last index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sclr  in  1  resynchronise: load the reset values.
- enable  in  1  cycle qualifier; counting advances only when this is high.
- interlaced  in  1  selects two-field mode.
- h_total  in  H_WIDTH  samples per line.
- v_total_f0, v_total_f1  in  V_WIDTH each  lines in field 0 and in field 1.
- h_reset  in  H_WIDTH  value loaded into h_count on sclr.
- v_reset  in  V_WIDTH  value loaded into v_count on sclr.
- f_reset  in  1  value used for field on sclr.
- h_count  out  H_WIDTH  registered horizontal sample index.
- v_count  out  V_WIDTH  registered line index within the current field.
- field  out  1  registered current field.
- sample_ticks  out  LOG2_NUMBER_OF_COLOUR_PLANES  registered plane index within the sample.
- start_of_sample  out  1  high when sample_ticks is 0.
- new_line, new_field, new_frame  out  1 each  combinational boundary strobes.

## Operation
- Derived constants and limits:
  - P = COLOUR_PLANES_ARE_IN_PARALLEL ? 1 : NUMBER_OF_COLOUR_PLANES.
  - h_last = TOTALS_MINUS_ONE ? h_total : h_total-1, computed modulo 2^H_WIDTH. An h_total of 0 therefore counts to the all-ones value.
  - v_last is (field ? v_total_f1 : v_total_f0), with the same minus-one rule, computed modulo 2^V_WIDTH.
- Sample sequencer:
  - sample_ticks wraps from P-1 to 0 and otherwise increments, on each enabled cycle.
  - When P=1 it stays at 0.
  - count_sample = enable && (sample_ticks == P-1).
- Boundary strobes:
  - new_line = count_sample && (h_count >= h_last).
  - new_field = new_line && (v_count >= v_last).
  - new_frame = new_field && (!interlaced || field).
- Counter updates, in priority order (first matching rule applies):
  1. rst: every register clears to 0.
  2. sclr: h_count=h_reset, v_count=v_reset, field=f_reset & interlaced, sample_ticks=0. sclr overrides enable.
  3. new_line: h_count=0.
     - If new_field is also high: v_count=0, and field toggles when interlaced is 1 (otherwise it becomes 0).
     - Otherwise v_count increments by 1.
  4. count_sample without new_line: h_count increments by 1.
- Comparisons use >=. If a total is reprogrammed below the current count, the line or field ends at the next count_sample.
- interlaced is sampled every cycle. If it is deasserted while field=1, field clears at the next new_field, and new_frame fires at that boundary.

## Timing
- Reset values: h_count=0, v_count=0, field=0, sample_ticks=0, start_of_sample=1. The strobes are 0 while rst is high.
- Counter latency is one cycle: values update on the clk edge that ends the qualifying enable cycle.
- Strobes are combinational from the registers and the current inputs. They are valid only during the cycle that causes the wrap, and at most one cycle wide per event.
- With enable low, all registers hold and all strobes are 0.

## Configuration
- VIPCTI_ACTIVE_FLAGS_EN defined:
  - Adds H_WIDTH-bit inputs h_active_start and h_active_end, V_WIDTH-bit inputs v_active_start and v_active_end, and a 1-bit output active_picture.
  - active_picture = (h_active_start <= h_count < h_active_end) && (v_active_start <= v_count < v_active_end).
  - It is combinational from the registered counts, so it has zero latency relative to h_count/v_count. It is 0 under rst.
- VIPCTI_ACTIVE_FLAGS_EN undefined: these ports and the associated logic do not exist.

## Test plan
- Progressive raster, parallel planes: P=1, h_total=4, v_total_f0=3, interlaced=0, enable held high. Require h_count to cycle 0..3, new_line every 4th cycle, and v_count to cycle 0..2. new_frame fires at h=3,v=2 (cycle 11, then every 12 cycles), and field stays 0.
- Sequential planes: NUMBER_OF_COLOUR_PLANES=3, parallel=0, h_total=2. Require sample_ticks to run 0,1,2, h_count to advance only when ticks=2, and new_line once every 6 enabled cycles.
- Interlaced raster: v_total_f0=3, v_total_f1=2, h_total=2. Require new_field after 6 then 4 lines' worth of samples, field to toggle 0→1→0, and new_frame only at the end of field 1.
- sclr mid-line with enable high: h_reset=5, v_reset=7, f_reset=1, interlaced=1. On the next cycle require h=5, v=7, field=1, ticks=0; no increment that cycle.
- Gaps and reset: enable low for 10 cycles mid-line holds every count with strobes at 0. Then assert rst for 1 cycle during new_field: all outputs return to their reset values, with no field toggle.
- VIPCTI_ACTIVE_FLAGS_EN with active window h 1..2, v 1..1: active_picture is high exactly when h_count∈{1,2} and v_count=1.
